// File: rtl/alu_issue_stage.sv
// Single-register issue stage feeding a combinational ALU: decode, NZCV flags, condition squash.
// Optional statistics counters are enabled with `define ISSUE_STATS_EN.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Instr,
    input  logic              Instr_Valid,
    output logic              Instr_Ready,
    output logic [REG_AW-1:0] Rn_Addr,
    output logic [REG_AW-1:0] Rm_Addr,
    input  logic [DATA_W-1:0] Rn_Data,
    input  logic [DATA_W-1:0] Rm_Data,
    output logic [DATA_W-1:0] In1,
    output logic [DATA_W-1:0] In2,
    output logic [3:0]        Opcode,
    output logic [3:0]        Cond,
    output logic              S,
    output logic [2:0]        SR_Cont,
    output logic [4:0]        SR_Bit,
    output logic [15:0]       Immediate,
    output logic [REG_AW-1:0] Rd,
    output logic              Issue_Valid,
    input  logic              Alu_Ready,
    input  logic [3:0]        Flags_In,
    output logic [3:0]        Flags_Out,
    output logic              Squash
`ifdef ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0]  Issue_Count,
    output logic [CNT_W-1:0]  Squash_Count,
    output logic [CNT_W-1:0]  Stall_Count
`endif
);

    localparam logic [3:0] OP_MOV_IMM = 4'b0110;

    logic              stage_valid_q;
    logic [3:0]        cond_q, opcode_q, nzcv_q;
    logic              s_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] in1_q, in2_q;
    logic [2:0]        sr_cont_q;
    logic [4:0]        sr_bit_q;
    logic [15:0]       imm_q;

    logic [DATA_W-1:0] in1_d, in2_d;
    logic [2:0]        sr_cont_d;
    logic [4:0]        sr_bit_d;
    logic [15:0]       imm_d;
    logic              is_mov;
    logic              pass, issue, squash, retire, accept;

    assign Rn_Addr = Instr[17:13];
    assign Rm_Addr = Instr[12:8];
    assign is_mov  = (Instr[27:24] == OP_MOV_IMM);

    always_comb begin
        in1_d     = Rn_Data;
        in2_d     = Rm_Data;
        sr_cont_d = Instr[7:5];
        sr_bit_d  = Instr[4:0];
        imm_d     = 16'd0;
        if (is_mov) begin
            in1_d     = '0;
            in2_d     = '0;
            sr_cont_d = 3'd0;
            sr_bit_d  = 5'd0;
            imm_d     = Instr[15:0];
        end
    end

    // nzcv_q = {N, Z, C, V}
    always_comb begin
        pass = 1'b0;
        case (cond_q)
            4'b0000: pass = nzcv_q[2];
            4'b0001: pass = !nzcv_q[2];
            4'b0010: pass = nzcv_q[1];
            4'b0011: pass = !nzcv_q[1];
            4'b0100: pass = nzcv_q[3];
            4'b0101: pass = !nzcv_q[3];
            4'b0110: pass = nzcv_q[0];
            4'b0111: pass = !nzcv_q[0];
            4'b1000: pass = nzcv_q[1] && !nzcv_q[2];
            4'b1001: pass = !nzcv_q[1] || nzcv_q[2];
            4'b1010: pass = (nzcv_q[3] == nzcv_q[0]);
            4'b1011: pass = (nzcv_q[3] != nzcv_q[0]);
            4'b1100: pass = !nzcv_q[2] && (nzcv_q[3] == nzcv_q[0]);
            4'b1101: pass = nzcv_q[2] || (nzcv_q[3] != nzcv_q[0]);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign issue  = stage_valid_q && pass;
    assign squash = stage_valid_q && !pass;
    assign retire = squash || (issue && Alu_Ready);
    assign accept = Instr_Valid && Instr_Ready;

    assign Instr_Ready = !stage_valid_q || retire;
    assign Issue_Valid = issue;
    assign Squash      = squash;
    assign Flags_Out   = nzcv_q;
    assign In1         = in1_q;
    assign In2         = in2_q;
    assign Opcode      = opcode_q;
    assign Cond        = cond_q;
    assign S           = s_q;
    assign SR_Cont     = sr_cont_q;
    assign SR_Bit      = sr_bit_q;
    assign Immediate   = imm_q;
    assign Rd          = rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            nzcv_q        <= 4'd0;
            cond_q        <= 4'd0;
            opcode_q      <= 4'd0;
            s_q           <= 1'b0;
            rd_q          <= '0;
            in1_q         <= '0;
            in2_q         <= '0;
            sr_cont_q     <= 3'd0;
            sr_bit_q      <= 5'd0;
            imm_q         <= 16'd0;
        end else begin
            // Squashed instructions never reach this write, so they cannot touch NZCV.
            if (issue && Alu_Ready && s_q) begin
                nzcv_q <= Flags_In;
            end
            if (accept) begin
                stage_valid_q <= 1'b1;
                cond_q        <= Instr[31:28];
                opcode_q      <= Instr[27:24];
                s_q           <= Instr[23];
                rd_q          <= Instr[22:18];
                in1_q         <= in1_d;
                in2_q         <= in2_d;
                sr_cont_q     <= sr_cont_d;
                sr_bit_q      <= sr_bit_d;
                imm_q         <= imm_d;
            end else if (retire) begin
                stage_valid_q <= 1'b0;
            end
        end
    end

`ifdef ISSUE_STATS_EN
    logic [CNT_W-1:0] issue_cnt_q, squash_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q  <= '0;
            squash_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (issue && Alu_Ready && (issue_cnt_q != '1)) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            if (squash && (squash_cnt_q != '1)) begin
                squash_cnt_q <= squash_cnt_q + 1'b1;
            end
            if (issue && !Alu_Ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign Issue_Count  = issue_cnt_q;
    assign Squash_Count = squash_cnt_q;
    assign Stall_Count  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_issue_stage;

    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Instr = '0;
    logic        Instr_Valid = 1'b0;
    logic        Instr_Ready;
    logic [4:0]  Rn_Addr, Rm_Addr;
    logic [31:0] Rn_Data = '0, Rm_Data = '0;
    logic [31:0] In1, In2;
    logic [3:0]  Opcode, Cond;
    logic        S;
    logic [2:0]  SR_Cont;
    logic [4:0]  SR_Bit;
    logic [15:0] Immediate;
    logic [4:0]  Rd;
    logic        Issue_Valid;
    logic        Alu_Ready = 1'b1;
    logic [3:0]  Flags_In = '0;
    logic [3:0]  Flags_Out;
    logic        Squash;
`ifdef ISSUE_STATS_EN
    logic [CNT_W-1:0] Issue_Count, Squash_Count, Stall_Count;
`endif

    alu_issue_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .Instr_Valid(Instr_Valid),
        .Instr_Ready(Instr_Ready), .Rn_Addr(Rn_Addr), .Rm_Addr(Rm_Addr),
        .Rn_Data(Rn_Data), .Rm_Data(Rm_Data), .In1(In1), .In2(In2),
        .Opcode(Opcode), .Cond(Cond), .S(S), .SR_Cont(SR_Cont), .SR_Bit(SR_Bit),
        .Immediate(Immediate), .Rd(Rd), .Issue_Valid(Issue_Valid),
        .Alu_Ready(Alu_Ready), .Flags_In(Flags_In), .Flags_Out(Flags_Out),
        .Squash(Squash)
`ifdef ISSUE_STATS_EN
        , .Issue_Count(Issue_Count), .Squash_Count(Squash_Count), .Stall_Count(Stall_Count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cond, op;
        logic        s;
        logic [4:0]  rd;
        logic [31:0] in1, in2;
        logic [2:0]  src;
        logic [4:0]  srb;
        logic [15:0] imm;
    } fields_t;

    int n_vec = 0;
    int n_err = 0;

    // reference state: one optional instruction in flight plus the flag register
    bit      m_known = 0;
    bit      m_valid;
    fields_t m_f;
    logic [3:0] m_nzcv;
    int      m_issue_cnt, m_squash_cnt, m_stall_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic fields_t decode(input logic [31:0] ins, input logic [31:0] rn, input logic [31:0] rm);
        fields_t f;
        f.cond = ins[31:28];
        f.op   = ins[27:24];
        f.s    = ins[23];
        f.rd   = ins[22:18];
        if (f.op == 4'b0110) begin
            f.in1 = 0; f.in2 = 0; f.src = 0; f.srb = 0; f.imm = ins[15:0];
        end else begin
            f.in1 = rn; f.in2 = rm; f.src = ins[7:5]; f.srb = ins[4:0]; f.imm = 0;
        end
        return f;
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;             1: return !z;
            2: return cy;            3: return !cy;
            4: return n;             5: return !n;
            6: return v;             7: return !v;
            8: return cy && !z;      9: return !cy || z;
            10: return n == v;       11: return n != v;
            12: return !z && n == v; 13: return z || n != v;
            14: return 1;            default: return 0;
        endcase
    endfunction

    function automatic int sat_inc(input int x);
        return (x == (1 << CNT_W) - 1) ? x : x + 1;
    endfunction

    task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                        input logic [31:0] rn, input logic [31:0] rm,
                        input logic ar, input logic [3:0] fl);
        bit p, e_issue, e_squash, e_ready;
        @(posedge clk);
        #1;
        rst = r; Instr_Valid = iv; Instr = ins; Rn_Data = rn; Rm_Data = rm;
        Alu_Ready = ar; Flags_In = fl;
        #5;
        p        = cond_ok(m_f.cond, m_nzcv);
        e_issue  = m_valid && p;
        e_squash = m_valid && !p;
        e_ready  = !m_valid || e_squash || (e_issue && ar);
        chk("rn_addr", 32'(Rn_Addr), 32'(ins[17:13]));
        chk("rm_addr", 32'(Rm_Addr), 32'(ins[12:8]));
        if (m_known) begin
            chk("issue_valid", 32'(Issue_Valid), 32'(e_issue));
            chk("squash", 32'(Squash), 32'(e_squash));
            chk("instr_ready", 32'(Instr_Ready), 32'(e_ready));
            chk("flags_out", 32'(Flags_Out), 32'(m_nzcv));
            if (m_valid) begin
                chk("in1", In1, m_f.in1);
                chk("in2", In2, m_f.in2);
                chk("opcode", 32'(Opcode), 32'(m_f.op));
                chk("cond", 32'(Cond), 32'(m_f.cond));
                chk("s", 32'(S), 32'(m_f.s));
                chk("rd", 32'(Rd), 32'(m_f.rd));
                chk("imm", 32'(Immediate), 32'(m_f.imm));
                if (m_f.op != 4'b0110) begin
                    chk("sr_cont", 32'(SR_Cont), 32'(m_f.src));
                    chk("sr_bit", 32'(SR_Bit), 32'(m_f.srb));
                end
            end
`ifdef ISSUE_STATS_EN
            chk("issue_count", 32'(Issue_Count), 32'(m_issue_cnt));
            chk("squash_count", 32'(Squash_Count), 32'(m_squash_cnt));
            chk("stall_count", 32'(Stall_Count), 32'(m_stall_cnt));
`endif
        end
        // advance the model across the coming edge
        if (r) begin
            m_known = 1; m_valid = 0; m_nzcv = 0;
            m_f = decode(32'h0, 0, 0);
            m_f.cond = 0;
            m_issue_cnt = 0; m_squash_cnt = 0; m_stall_cnt = 0;
        end else if (m_known) begin
            if (e_issue && ar) m_issue_cnt = sat_inc(m_issue_cnt);
            if (e_squash) m_squash_cnt = sat_inc(m_squash_cnt);
            if (e_issue && !ar) m_stall_cnt = sat_inc(m_stall_cnt);
            if (e_issue && ar && m_f.s) m_nzcv = fl;
            if (iv && e_ready) begin
                m_f = decode(ins, rn, rm);
                m_valid = 1;
            end else if (e_squash || (e_issue && ar)) begin
                m_valid = 0;
            end
        end
    endtask

    initial begin
        logic [31:0] ins;
        // reset held two cycles
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("rst_flags", 32'(Flags_Out), 0);
        chk("rst_issue", 32'(Issue_Valid), 0);
        chk("rst_ready", 32'(Instr_Ready), 1);
        chk("rst_in1", In1, 0);
        chk("rst_in2", In2, 0);
        chk("rst_opimm", {Opcode, Cond, 7'd0, S, Immediate}, 0);
        chk("rst_misc", {24'd0, SR_Cont, SR_Bit}, 0);

        // ADD AL, Rn=1 Rm=3
        step(0, 1, 32'hE000_2300, 15, 20, 1, 0);
        chk("add_ready", 32'(Instr_Ready), 1);
        chk("add_rn", 32'(Rn_Addr), 1);
        chk("add_rm", 32'(Rm_Addr), 3);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("add_issue", 32'(Issue_Valid), 1);
        chk("add_op", 32'(Opcode), 0);
        chk("add_in1", In1, 15);
        chk("add_in2", In2, 20);

        // SUB S=1 writes Z, EQ then NE
        step(0, 1, 32'hE280_0000, 5, 5, 1, 0);
        step(0, 1, 32'h0000_0000, 1, 2, 1, 4'b0100);
        chk("sub_issue", 32'(Issue_Valid), 1);
        step(0, 1, 32'h1000_0000, 3, 4, 1, 4'b0000);
        chk("eq_issue", 32'(Issue_Valid), 1);
        chk("eq_flags", 32'(Flags_Out), 4'b0100);
        step(0, 0, 0, 0, 0, 1, 4'b1111);
        chk("ne_squash", 32'(Squash), 1);
        chk("ne_issue", 32'(Issue_Valid), 0);
        step(0, 0, 0, 0, 0, 1, 4'b1111);
        chk("ne_squash_end", 32'(Squash), 0);
        chk("ne_flags", 32'(Flags_Out), 4'b0100);

        // MOV imm
        step(0, 1, 32'hE600_003C, 32'hDEAD, 32'hBEEF, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("mov_imm", 32'(Immediate), 60);
        chk("mov_op", 32'(Opcode), 4'b0110);
        chk("mov_in1", In1, 0);
        chk("mov_in2", In2, 0);

        // backpressure: three stall cycles with a waiting instruction
        step(0, 1, 32'hE000_2300, 7, 8, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'hE100_4500, 30, 40, 0, 0);
            chk("bp_issue", 32'(Issue_Valid), 1);
            chk("bp_ready", 32'(Instr_Ready), 0);
            chk("bp_in1", In1, 7);
        end
        step(0, 1, 32'hE100_4500, 30, 40, 1, 0);
        chk("bp_release", 32'(Instr_Ready), 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("bp_next_issue", 32'(Issue_Valid), 1);
        chk("bp_next_in1", In1, 30);

        // reset during a stall
        step(0, 1, 32'hE000_2300, 9, 9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("ms_stall", 32'(Issue_Valid), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("ms_issue", 32'(Issue_Valid), 0);
        chk("ms_ready", 32'(Instr_Ready), 1);
`ifdef ISSUE_STATS_EN
        chk("ms_stall_cnt", 32'(Stall_Count), 0);
`endif

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) == 0) ins[27:24] = 4'b0110;
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80), ins,
                 $urandom, $urandom, ($urandom_range(0, 99) < 70), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
